cnn_mac_acc_sat: RTL and testbench
==================================

// Module: cnn_mac_acc_sat
// PURPOSE
//  Downstream consumer of the 10s x 14s conv multiplier: accumulates ACC_LEN signed
//  products (one conv kernel window) into a wide accumulator.
//  Rescales by FRAC_SHIFT with round-half-up, saturates to OUT_W and emits one feature
//  value per window over a valid/ready handshake toward the pooling/next-layer stage.
// PARAMETERS
//  PROD_W     25  signed product width from multiplier
//  ACC_W      32  accumulator width; must be >= PROD_W+clog2(ACC_LEN) (no acc overflow)
//  ACC_LEN    25  products per output (5x5 kernel); legal range 1..1024
//  FRAC_SHIFT 10  arithmetic right shift applied to the final sum; legal range 1..ACC_W-1
//  OUT_W      14  signed output width (feature-map data width)
// PORTS
//  ap_clk    in   1        clock, rising edge
//  ap_rst    in   1        asynchronous active-high reset
//  prod_dat  in   PROD_W   signed product from multiplier
//  prod_vld  in   1        prod_dat valid
//  prod_rdy  out  1        block accepts prod_dat this cycle
//  out_dat   out  OUT_W    signed rescaled, saturated window result
//  out_vld   out  1        out_dat valid
//  out_rdy   in   1        downstream accepts out_dat
//  sat_flag  out  1        sticky: some output was clipped since reset
//  busy      out  1        high while a window is partially accumulated or result pending
// BEHAVIOUR
//  Reset (async, ap_rst=1): state=ACC, acc=0, cnt=0, out_dat=0, out_vld=0, sat_flag=0,
//   busy=0; prod_rdy=1 immediately after release.
//  FSM, 2 states:
//   ACC: prod_rdy=1, out_vld=0. Accept = prod_vld&prod_rdy. On accept with cnt<ACC_LEN-1:
//        acc<=acc+sext(prod_dat), cnt<=cnt+1. On accept with cnt==ACC_LEN-1:
//        sum=acc+sext(prod_dat); out_dat<=sat(rnd(sum)); acc<=0; cnt<=0;
//        out_vld<=1; -> OUT.
//   OUT: prod_rdy=0; out_dat/out_vld held stable. On out_rdy=1: out_vld<=0 -> ACC.
//  Latency: out_vld rises the cycle after the ACC_LEN-th accept.
//   Max rate: one result per ACC_LEN+1 cycles.
//  rnd(s) = (s + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, computed in ACC_W+1 bits (no wrap).
//  sat(r): r>2^(OUT_W-1)-1 -> 2^(OUT_W-1)-1; r<-2^(OUT_W-1) -> -2^(OUT_W-1); else r.
//   Any clip sets sat_flag (sticky until reset).
//  busy = (cnt!=0) | (state==OUT).
//  prod_vld while prod_rdy=0: ignored, no state change; upstream must hold data.
//  out_rdy while out_vld=0: ignored.
//  Reset mid-window or mid-OUT: partial sum and pending result discarded;
//   no output is emitted for that window.
//  ACC_LEN=1: every accepted product produces a result (ACC->OUT each time).
// CONFIGURATION
//  CNN_ACC_RELU_EN defined: after sat(), negative results are forced to 0
//   (out_dat>=0 always). A negative result is not a clip and does not set sat_flag.
//   Only positive clipping sets sat_flag.
//  CNN_ACC_RELU_EN undefined: signed saturated result passed through unchanged.
// TESTING (defaults unless noted)
//  1 25 products of +1024, out_rdy=1 -> sum 25600, out_dat=25 one cycle after 25th accept.
//    sat_flag stays 0.
//  2 25 products of +2^23 -> out_dat=8191, sat_flag=1 and stays 1 over following windows.
//  3 25 products of -2^23 -> out_dat=-8192; with CNN_ACC_RELU_EN -> out_dat=0.
//    With CNN_ACC_RELU_EN, sat_flag remains 0.
//  4 Rounding: 24x0 + one -512 -> out_dat=0; 24x0 + one +512 -> out_dat=1;
//    24x0 + one -513 -> out_dat=-1.
//  5 Backpressure: out_rdy=0 for 5 cycles after out_vld -> out_dat stable, prod_rdy=0,
//    prod_vld pulses ignored. out_rdy=1 -> out_vld drops next cycle, prod_rdy=1.
//  6 Assert ap_rst after 10 accepts, release -> all outputs at reset values, busy=0.
//    The next 25 products of +1024 yield out_dat=25 (no residue from the aborted window).

Source files
------------

// File: rtl/cnn_mac_acc_sat_if.sv
// Product-in / feature-out stream bundle for the conv MAC accumulator.
// master = upstream/downstream environment, slave = accumulator.
interface cnn_mac_acc_sat_if #(
    parameter int PROD_W = 25,
    parameter int OUT_W  = 14
);
    logic signed [PROD_W-1:0] prod_dat;
    logic                     prod_vld;
    logic                     prod_rdy;
    logic signed [OUT_W-1:0]  out_dat;
    logic                     out_vld;
    logic                     out_rdy;

    modport master (
        output prod_dat, prod_vld, out_rdy,
        input  prod_rdy, out_dat, out_vld
    );

    modport slave (
        input  prod_dat, prod_vld, out_rdy,
        output prod_rdy, out_dat, out_vld
    );
endinterface

// File: rtl/cnn_mac_acc_sat.sv
// Window accumulator: sum ACC_LEN products, round-half-up rescale, saturate.
// Optional CNN_ACC_RELU_EN clamps negative results to zero after saturation.
module cnn_mac_acc_sat #(
    parameter int PROD_W     = 25,
    parameter int ACC_W      = 32,
    parameter int ACC_LEN    = 25,
    parameter int FRAC_SHIFT = 10,
    parameter int OUT_W      = 14
) (
    input  logic ap_clk,
    input  logic ap_rst,
    cnn_mac_acc_sat_if.slave s,
    output logic sat_flag,
    output logic busy
);
    localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);

    localparam logic signed [ACC_W:0] HALF =
        {{ACC_W{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
    localparam logic signed [ACC_W:0] MAXV =
        (ACC_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W:0] MINV = -MAXV - 1;

    typedef enum logic {ACC, OUT} state_t;

    state_t                   state, state_n;
    logic signed [ACC_W-1:0]  acc, acc_n;
    logic        [CW-1:0]     cnt, cnt_n;
    logic signed [OUT_W-1:0]  dat, dat_n;
    logic                     sat_n;

    logic                     accept;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W:0]    rsum;
    logic signed [ACC_W:0]    rsh;
    logic signed [OUT_W-1:0]  res;
    logic                     clip;

    assign accept = s.prod_vld && (state == ACC);

    assign sum = acc + {{(ACC_W-PROD_W){s.prod_dat[PROD_W-1]}},
                        s.prod_dat};

    // One extra bit so adding the half-LSB can never wrap.
    assign rsum = {sum[ACC_W-1], sum} + HALF;
    assign rsh  = rsum >>> FRAC_SHIFT;

    always_comb begin
        res  = rsh[OUT_W-1:0];
        clip = 1'b0;
        if (rsh > MAXV) begin
            res  = MAXV[OUT_W-1:0];
            clip = 1'b1;
        end else if (rsh < MINV) begin
            res  = MINV[OUT_W-1:0];
`ifdef CNN_ACC_RELU_EN
            clip = 1'b0;
`else
            clip = 1'b1;
`endif
        end
`ifdef CNN_ACC_RELU_EN
        if (res[OUT_W-1]) res = '0;
`endif
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        dat_n   = dat;
        sat_n   = sat_flag;
        unique case (state)
            ACC: begin
                if (accept) begin
                    if (cnt == LAST) begin
                        dat_n   = res;
                        sat_n   = sat_flag | clip;
                        acc_n   = '0;
                        cnt_n   = '0;
                        state_n = OUT;
                    end else begin
                        acc_n = sum;
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            OUT: begin
                if (s.out_rdy) state_n = ACC;
            end
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state    <= ACC;
            acc      <= '0;
            cnt      <= '0;
            dat      <= '0;
            sat_flag <= 1'b0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            dat      <= dat_n;
            sat_flag <= sat_n;
        end
    end

    assign s.prod_rdy = (state == ACC);
    assign s.out_vld  = (state == OUT);
    assign s.out_dat  = dat;
    assign busy       = (cnt != '0) || (state == OUT);
endmodule

// File: tb/tb_cnn_mac_acc_sat.sv
// Directed + randomized bench for cnn_mac_acc_sat.
// Expected results come from an arithmetic window model.
module tb_cnn_mac_acc_sat;
    localparam int PROD_W     = 25;
    localparam int ACC_W      = 32;
    localparam int ACC_LEN    = 25;
    localparam int FRAC_SHIFT = 10;
    localparam int OUT_W      = 14;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    logic sat_flag;
    logic busy;

    int n_chk  = 0;
    int n_fail = 0;
    bit exp_sat = 1'b0;

    always #5 ap_clk = ~ap_clk;

    cnn_mac_acc_sat_if #(.PROD_W(PROD_W), .OUT_W(OUT_W)) bus ();

    cnn_mac_acc_sat #(
        .PROD_W    (PROD_W),
        .ACC_W     (ACC_W),
        .ACC_LEN   (ACC_LEN),
        .FRAC_SHIFT(FRAC_SHIFT),
        .OUT_W     (OUT_W)
    ) dut (
        .ap_clk  (ap_clk),
        .ap_rst  (ap_rst),
        .s       (bus.slave),
        .sat_flag(sat_flag),
        .busy    (busy)
    );

    task automatic chk(input string tag, input longint obs,
                       input longint exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Exact integer sum, floor((sum + half) / 2^F), then clamp.
    function automatic longint model(input int q[$], output bit clip);
        longint sum = 0;
        longint r;
        longint hi = (64'sd1 <<< (OUT_W - 1)) - 1;
        longint lo = -(64'sd1 <<< (OUT_W - 1));
        foreach (q[i]) sum += longint'(q[i]);
        r = (sum + (64'sd1 <<< (FRAC_SHIFT - 1))) >>> FRAC_SHIFT;
        clip = 1'b0;
        if (r > hi) begin
            r = hi;
            clip = 1'b1;
        end else if (r < lo) begin
            r = lo;
`ifndef CNN_ACC_RELU_EN
            clip = 1'b1;
`endif
        end
`ifdef CNN_ACC_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    task automatic feed(input int q[$]);
        @(negedge ap_clk);
        foreach (q[i]) begin
            int n = 0;
            while (!bus.prod_rdy && n < 200) begin
                @(negedge ap_clk);
                n++;
            end
            if (n >= 200) chk("prod_rdy_timeout", 0, 1);
            bus.prod_vld = 1'b1;
            bus.prod_dat = PROD_W'(q[i]);
            @(negedge ap_clk);
        end
        bus.prod_vld = 1'b0;
    endtask

    task automatic window(input int q[$], input int hold);
        longint e;
        bit clip;
        e = model(q, clip);
        exp_sat = exp_sat | clip;
        bus.out_rdy = 1'b0;
        feed(q);
        chk("out_vld_rise", bus.out_vld, 1);
        chk("out_dat", bus.out_dat, e);
        chk("sat_flag", sat_flag, exp_sat);
        chk("busy_out", busy, 1);
        repeat (hold) begin
            bus.prod_vld = 1'b1;
            bus.prod_dat = PROD_W'($urandom);
            @(negedge ap_clk);
            chk("hold_dat", bus.out_dat, e);
            chk("hold_vld", bus.out_vld, 1);
            chk("hold_prod_rdy", bus.prod_rdy, 0);
        end
        bus.prod_vld = 1'b0;
        bus.out_rdy  = 1'b1;
        @(negedge ap_clk);
        bus.out_rdy  = 1'b0;
        chk("out_vld_drop", bus.out_vld, 0);
        chk("prod_rdy_back", bus.prod_rdy, 1);
        chk("busy_idle", busy, 0);
        chk("sat_flag_after", sat_flag, exp_sat);
    endtask

    function automatic void fill_const(ref int q[$], input int v);
        q.delete();
        repeat (ACC_LEN) q.push_back(v);
    endfunction

    initial begin
        int q[$];
        int m;
        bus.prod_vld = 1'b0;
        bus.prod_dat = '0;
        bus.out_rdy  = 1'b0;
        repeat (3) @(negedge ap_clk);
        chk("rst_out_vld", bus.out_vld, 0);
        chk("rst_out_dat", bus.out_dat, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_busy", busy, 0);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("rel_prod_rdy", bus.prod_rdy, 1);

        fill_const(q, 1024);
        window(q, 0);
        fill_const(q, 1 << 23);
        window(q, 0);
        fill_const(q, 1024);
        window(q, 0);
        fill_const(q, -(1 << 23));
        window(q, 1);

        fill_const(q, 0);
        q[24] = -512;
        window(q, 0);
        q[7] = 512;
        q[24] = 0;
        window(q, 0);
        q[7] = 0;
        q[12] = -513;
        window(q, 0);

        fill_const(q, 1000);
        window(q, 5);

        for (int w = 0; w < 10; w++) begin
            m = (w % 3 == 0) ? (1 << 24) - 1 : (1 << 14) + w * 1000;
            q.delete();
            repeat (ACC_LEN)
                q.push_back(int'($urandom_range(0, 2 * m)) - m);
            window(q, int'($urandom_range(0, 3)));
        end

        q.delete();
        repeat (10) q.push_back(1024);
        feed(q);
        chk("busy_partial", busy, 1);
        #2 ap_rst = 1'b1;
        #1;
        exp_sat = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_vld", bus.out_vld, 0);
        chk("mid_rst_dat", bus.out_dat, 0);
        chk("mid_rst_sat", sat_flag, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        fill_const(q, 1024);
        window(q, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
